can_rec_bus_arbiter: RTL

CAN_REC_BUS_ARBITER -- requirements
Module: can_rec_bus_arbiter

---
 rtl/can_rec_bus_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/can_rec_bus_arbiter.sv
// Round-robin arbiter granting one CAN receive bus at a time to the uplink path,
// with per-grant timeout, a masked pending-request latch and registered outputs.
module can_rec_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  n_buses,
  input  logic [31:0] irq_can_rec,
  input  logic        end_rec,
  output logic [4:0]  can_rec_select,
  output logic        start_rec,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] pending
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_END, RELEASE} state_t;

  state_t      state_q;
  logic [31:0] pending_q, pending_d;
  logic [31:0] req_mask;
  logic [31:0] grant_clr;
  logic [5:0]  pick_d;
  logic [4:0]  rr_ptr_q;
  logic [4:0]  sel_q;
  logic [15:0] cnt_q;
  logic        start_q, busy_q, terr_q;

  function automatic logic [31:0] bus_mask(input logic [4:0] n);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (5'(i) <= n);
    return m;
  endfunction

  // Circular search from ptr; scanning offsets high-to-low lets the nearest hit win.
  function automatic logic [5:0] rr_pick(input logic [31:0] req, input logic [4:0] ptr);
    logic [5:0] r;
    logic [4:0] idx;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr + 5'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    req_mask  = bus_mask(n_buses);
    grant_clr = '0;
    if (state_q == GRANT) grant_clr[sel_q] = 1'b1;
    // A request arriving while its bit is being cleared re-queues the bus.
    pending_d = ((pending_q & ~grant_clr) | irq_can_rec) & req_mask;
    pick_d    = rr_pick(pending_q & req_mask, rr_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      start_q   <= 1'b0;
      terr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d[5]) begin
            sel_q   <= pick_d[4:0];
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_END;
        end
        WAIT_END: begin
          cnt_q <= cnt_q + 16'd1;
          // end_rec beats a timeout landing on the same cycle.
          if (end_rec) begin
            state_q <= RELEASE;
          end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
            terr_q  <= 1'b1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr_q <= (sel_q >= n_buses) ? 5'd0 : sel_q + 5'd1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign can_rec_select = sel_q;
  assign start_rec      = start_q;
  assign busy           = busy_q;
  assign timeout_err    = terr_q;
  assign pending        = pending_q;

endmodule
